// File: rtl/regs_wb_queue.sv
// Write-back buffer in front of the register memory.
// Collects register writes from the ALU and IO sources into an in-order FIFO,
// drains one entry per cycle into the memory write port, and forwards queued
// or just-accepted writes onto the registered read data so reads always see
// the latest accepted value.
module regs_wb_queue #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_addr,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     io_valid,
   output logic                     io_ready,
   input  logic [ADDR_W-1:0]        io_addr,
   input  logic [DATA_W-1:0]        io_data,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [ADDR_W-1:0]        mem_rd_addr,
   input  logic [DATA_W-1:0]        mem_q,
   output logic [DATA_W-1:0]        rd_q,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_wr_addr,
   output logic [DATA_W-1:0]        mem_d,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SP_W  = CNT_W + 1;

   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W-1:0]  io_slot;
   logic [CNT_W-1:0]  count;
   logic [SP_W-1:0]   space;
   logic              pop;
   logic              alu_fire;
   logic              io_fire;

   logic              byp_hit;
   logic [DATA_W-1:0] byp_data;
   logic [PTR_W-1:0]  scan_idx;
   logic              byp_hit_p1;
   logic [DATA_W-1:0] byp_data_p1;

   // The head drains every cycle the queue holds anything; the memory never stalls,
   // so the slot being popped is already free for a same-cycle enqueue.
   assign pop      = (count != '0);
   assign space    = SP_W'(DEPTH) - {1'b0, count} + SP_W'(pop);
   assign alu_ready = (space >= SP_W'(1));
   // IO only gets a slot that is left after a possible ALU enqueue.
   assign io_ready  = (space >= (SP_W'(1) + SP_W'(alu_valid)));
   assign alu_fire  = alu_valid & alu_ready;
   assign io_fire   = io_valid & io_ready;
   assign io_slot   = tail + PTR_W'(alu_fire);

   assign mem_we      = pop;
   assign mem_wr_addr = q_addr[head];
   assign mem_d       = q_data[head];
   assign mem_rd_addr = rd_addr;
   assign fifo_count  = count;

   // Queue pointers, occupancy and the bypass hit flag (control state, reset).
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         byp_hit_p1 <= 1'b0;
      end else begin
         head       <= head + PTR_W'(pop);
         tail       <= tail + PTR_W'(alu_fire) + PTR_W'(io_fire);
         count      <= count - CNT_W'(pop) + CNT_W'(alu_fire) + CNT_W'(io_fire);
         byp_hit_p1 <= byp_hit;
      end
   end

   // Queue storage and bypass data; ALU goes into the tail ahead of IO.
   always_ff @(posedge clk) begin
      if (alu_fire) begin
         q_addr[tail] <= alu_addr;
         q_data[tail] <= alu_data;
      end
      if (io_fire) begin
         q_addr[io_slot] <= io_addr;
         q_data[io_slot] <= io_data;
      end
      byp_data_p1 <= byp_data;
   end

   // Youngest matching write for rd_addr: scan head to tail, then ALU, then IO,
   // each later match overriding. The head is included because the memory read
   // at this edge does not see the write made at the same edge.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      scan_idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && (q_addr[scan_idx] == rd_addr)) begin
            byp_hit  = 1'b1;
            byp_data = q_data[scan_idx];
         end
      end
      if (alu_fire && (alu_addr == rd_addr)) begin
         byp_hit  = 1'b1;
         byp_data = alu_data;
      end
      if (io_fire && (io_addr == rd_addr)) begin
         byp_hit  = 1'b1;
         byp_data = io_data;
      end
   end

   // ---- read data stage (cycle n+1) ----
   assign rd_q = byp_hit_p1 ? byp_data_p1 : mem_q;

endmodule
